mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Load/store sequencer between the decode/control stage and the data-memory bus. Consumes the control unit's `mr`, `mw` and `MemType` (funct3) with the computed address and store data, runs a req/ack bus transaction with byte enables, stalls the pipeline while the access is outstanding, and returns an aligned, sign- or zero-extended load result. It sits in the MEM stage, on the datapath feeding `mtr = 01` writeback.

## Interface
- `TIMEOUT_CYC`, 16: max cycles in BUSY without `bus_ack` before abort (≥1, fits 8 bits)
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `mr`  in  1  load request from control
- `mw`  in  1  store request from control
- `mem_type`  in  3  funct3 of the access (000 B, 001 H, 010 W, 100 BU, 101 HU)
- `addr`  in  32  byte address from ALU
- `wdata`  in  32  store data (rs2)
- `stall`  out  1  hold the pipeline
- `rdata`  out  32  extended load result
- `rdata_valid`  out  1  one-cycle pulse, load complete
- `err`  out  1  one-cycle pulse: illegal `mem_type` or timeout
- `misalign`  out  1  one-cycle pulse, misaligned access (see Configuration)
- `bus_req`  out  1  bus request, held until ack
- `bus_we`  out  1  1 = write
- `bus_addr`  out  32  word address (`{addr[31:2],2'b00}`)
- `bus_be`  out  4  byte enables
- `bus_wdata`  out  32  lane-replicated store data
- `bus_ack`  in  1  bus completion; `bus_rdata` is valid the same cycle
- `bus_rdata`  in  32  read word

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - If `mr|mw`: latch `addr`, `mem_type`, `wdata`, direction.
  - `mr` wins if both are set.
  - Legal access → BUSY.
  - Illegal `mem_type` (load 011/110/111, store ≥011) → DONE with `err`, no bus cycle.
- BUSY:
  - `bus_req` = 1 and all bus outputs are held stable.
  - `bus_ack` → DONE.
  - A cycle counter counts cycles in BUSY. When it reaches `TIMEOUT_CYC` with no ack, the access aborts → DONE with `err`. Load `rdata` = 0.
- DONE: exactly one cycle, then → IDLE. `mr`/`mw` are ignored in DONE, because they still belong to the completing instruction.
- `stall` (combinational) = (IDLE & (`mr`|`mw`)) | BUSY. `stall` is 0 in DONE.
- Byte lanes, with `off = addr[1:0]`:
  - B: `be = 0001<<off`, `bus_wdata = {4{wdata[7:0]}}`.
  - H: `be = 0011<<(2*off[1])`, `bus_wdata = {2{wdata[15:0]}}`.
  - W: `be = 1111`, `bus_wdata = wdata`.
- Loads:
  - Select the byte/half at the same lane from `bus_rdata`.
  - Sign-extend for 000/001; zero-extend for 100/101.
  - Register the result into `rdata` on ack.
  - `rdata` holds its value until the next load completes.
- `bus_ack` outside BUSY is ignored, including a late ack after timeout.
- `rst`: state → IDLE, counter cleared, any in-flight access dropped.

## Timing
- Reset values: `bus_req`, `bus_we`, `rdata_valid`, `err`, `misalign` = 0; `bus_addr`, `bus_be`, `bus_wdata`, `rdata` = 0.
- Cycle N: IDLE sees `mr`. `stall` = 1. `bus_req` rises at N+1.
- Ack at cycle N+k (k≥1):
  - N+k+1 is DONE, with `rdata_valid` (loads) and `stall` = 0.
  - The pipeline advances at the end of N+k+1.
- Minimum access latency, zero-wait bus (ack in the first BUSY cycle): 3 cycles (N, N+1, N+2), 2 of them stalled.
- `bus_req` falls in the DONE cycle.
- Timeout: DONE in cycle N+1+`TIMEOUT_CYC`, with `err` = 1 there.
- Illegal type: DONE in N+1, with `err` = 1.
- `rst` asserted in any cycle: all registered outputs are at reset values on the next cycle, with no DONE pulse.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - H with `addr[0]`=1, or W with `addr[1:0]`≠0, goes IDLE → DONE with no bus cycle.
  - `misalign` = 1 in DONE; load `rdata` = 0, no `rdata_valid`.
- Not defined:
  - `misalign` is tied 0.
  - Low address bits that the type cannot use are dropped: H uses `off[1]` only, W ignores `off`.

## Test plan
- LW, `addr`=0x100, ack in first BUSY cycle, `bus_rdata`=0xDEADBEEF → `bus_be`=1111, `bus_addr`=0x100, `rdata`=0xDEADBEEF, `rdata_valid` 2 cycles after request, `stall` high 2 cycles.
- LB `addr`=0x103 then LBU `addr`=0x103, `bus_rdata`=0x80FF_0000 → `be`=1000; `rdata` 0xFFFFFF80 then 0x00000080.
- SH `addr`=0x202, `wdata`=0x1234ABCD, ack after 3 wait cycles → `bus_we`=1, `be`=1100, `bus_wdata`=0xABCDABCD, held stable for all 4 BUSY cycles.
- LW with no ack, `TIMEOUT_CYC`=16 → `bus_req` high 16 cycles, `err` pulse, `rdata`=0; a later stray ack is ignored and the next request is served normally.
- `mem_type`=011 load → `err` pulse in N+1, `bus_req` never rises. `rst` asserted in BUSY → `bus_req`=0 the next cycle, no `rdata_valid`.
- LH `addr`=0x101:
  - With `MEM_MISALIGN_TRAP_EN`: `misalign` pulse, no bus cycle.
  - Without: `be`=0011, normal completion.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between decode/control and the data-memory req/ack bus (optional trap: MEM_MISALIGN_TRAP_EN).
// Latency: request seen in IDLE, bus_req next cycle, result/pulse one cycle after bus_ack (3 cycles minimum).
// Backpressure: stall holds the pipeline from request until the DONE cycle; aborts after TIMEOUT_CYC unacked cycles.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mr,
    input  logic        mw,
    input  logic [2:0]  mem_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        err,
    output logic        misalign,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic        ld_q;
    logic [2:0]  type_q;
    logic [1:0]  off_q;
    logic        req, legal, mis_in, timeout;
    logic [3:0]  be_in;
    logic [31:0] wdata_in, load_ext;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign req     = mr | mw;
    assign timeout = (cnt == TO_LAST);
    assign bus_req = (state == BUSY);
    assign stall   = ((state == IDLE) & req) | (state == BUSY);

    // Loads accept the unsigned variants; stores only B/H/W.
    always_comb begin
        legal = 1'b0;
        if (mr) legal = (mem_type inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        else    legal = (mem_type inside {3'b000, 3'b001, 3'b010});
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis_in = ((mem_type[1:0] == 2'b01) & addr[0]) |
                    ((mem_type[1:0] == 2'b10) & (|addr[1:0]));
`else
    assign mis_in = 1'b0;
`endif

    always_comb begin
        be_in    = 4'b1111;
        wdata_in = wdata;
        case (mem_type[1:0])
            2'b00: begin
                be_in    = 4'b0001 << addr[1:0];
                wdata_in = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_in    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign byte_lane = bus_rdata[{off_q, 3'b000} +: 8];
    assign half_lane = bus_rdata[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = bus_rdata;
        case (type_q)
            3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
            3'b100:  load_ext = {24'b0, byte_lane};
            3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
            3'b101:  load_ext = {16'b0, half_lane};
            default: ;
        endcase
    end

    // DONE never re-samples mr/mw: they still belong to the completing instruction.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = (legal && !mis_in) ? BUSY : DONE;
            BUSY:    if (bus_ack || timeout) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            ld_q        <= 1'b0;
            type_q      <= '0;
            off_q       <= '0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_be      <= '0;
            bus_wdata   <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            rdata_valid <= 1'b0;
            err         <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req) begin
                        ld_q      <= mr;
                        type_q    <= mem_type;
                        off_q     <= addr[1:0];
                        bus_we    <= ~mr;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_be    <= be_in;
                        bus_wdata <= wdata_in;
                        if (!legal)           err   <= 1'b1;
                        else if (mis_in && mr) rdata <= '0;
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        if (ld_q) begin
                            rdata       <= load_ext;
                            rdata_valid <= 1'b1;
                        end
                    end else if (timeout) begin
                        err <= 1'b1;
                        if (ld_q) rdata <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) misalign <= 1'b0;
        else     misalign <= (state == IDLE) & req & legal & mis_in;
    end
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed + random load/store sequences against an arithmetic reference of the lane/extension rules.
module tb_mem_access_ctrl;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst, mr, mw, bus_ack;
    logic [2:0]  mem_type;
    logic [31:0] addr, wdata, bus_rdata;
    logic        stall, rdata_valid, err, misalign, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_rdata = '0;

    mem_access_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .mr(mr), .mw(mw), .mem_type(mem_type),
        .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
        .rdata_valid(rdata_valid), .err(err), .misalign(misalign),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_legal(input bit ld, input logic [2:0] mt);
        if (ld) return (mt == 0 || mt == 1 || mt == 2 || mt == 4 || mt == 5);
        return (mt <= 2);
    endfunction

    function automatic bit m_mis(input logic [2:0] mt, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
        if (mt[1:0] == 1) return (a % 2) != 0;
        if (mt[1:0] == 2) return (a % 4) != 0;
`endif
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] mt, input logic [31:0] a);
        if (mt[1:0] == 0) return 4'(1 << (a % 4));
        if (mt[1:0] == 1) return 4'(3 << (2 * ((a % 4) / 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] mt, input logic [31:0] wd);
        if (mt[1:0] == 0) return (wd & 32'hFF) * 32'h0101_0101;
        if (mt[1:0] == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] mt, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        if (mt[1:0] == 0) begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            if (!mt[2] && v >= 128) v = v - 256;
        end else if (mt[1:0] == 1) begin
            v = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
            if (!mt[2] && v >= 32768) v = v - 65536;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // delay = BUSY cycle carrying bus_ack (1 = first); 0 = never ack.
    task automatic access(input bit ld, input logic [2:0] mt, input logic [31:0] a,
                          input logic [31:0] wd, input int delay, input logic [31:0] rd);
        bit lg, ms, done;
        int c;
        lg = m_legal(ld, mt);
        ms = lg && m_mis(mt, a);
        mr = ld; mw = !ld; mem_type = mt; addr = a; wdata = wd; bus_ack = 0;
        #1 chk("stall_req", stall, 1);
        @(posedge clk); #1;
        if (!lg || ms) begin
            chk("err_nobus", err, !lg);
            chk("mis_nobus", misalign, ms);
            chk("req_nobus", bus_req, 0);
            chk("vld_nobus", rdata_valid, 0);
            chk("stall_nobus", stall, 0);
            if (ld && ms) exp_rdata = 0;
            chk("rdata_nobus", rdata, exp_rdata);
        end else begin
            c = 0; done = 0;
            while (!done) begin
                c++;
                chk("bus_req", bus_req, 1);
                chk("bus_we", bus_we, !ld);
                chk("bus_addr", bus_addr, a & ~32'h3);
                chk("bus_be", bus_be, m_be(mt, a));
                if (!ld) chk("bus_wdata", bus_wdata, m_wd(mt, wd));
                chk("stall_busy", stall, 1);
                if (c == delay) begin bus_ack = 1; bus_rdata = rd; end
                @(posedge clk); #1;
                bus_ack = 0; bus_rdata = $urandom;
                if (c == delay || c == TO) done = 1;
            end
            if (delay >= 1 && delay <= TO) begin
                chk("vld_done", rdata_valid, ld);
                chk("err_done", err, 0);
                if (ld) exp_rdata = m_load(mt, a, rd);
            end else begin
                chk("vld_timeout", rdata_valid, 0);
                chk("err_timeout", err, 1);
                if (ld) exp_rdata = 0;
            end
            chk("rdata_done", rdata, exp_rdata);
            chk("stall_done", stall, 0);
            chk("req_done", bus_req, 0);
            chk("mis_done", misalign, 0);
        end
        mr = 0; mw = 0;
        @(posedge clk); #1;
        chk("req_after", bus_req, 0);
        chk("pulse_after", {29'b0, rdata_valid, err, misalign}, 0);
    endtask

    initial begin
        rst = 1; mr = 0; mw = 0; mem_type = 0; addr = 0; wdata = 0;
        bus_ack = 0; bus_rdata = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_req", bus_req, 0);
        chk("rst_we", bus_we, 0);
        chk("rst_pulses", {29'b0, rdata_valid, err, misalign}, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_be", bus_be, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_stall", stall, 0);

        access(1, 3'b010, 32'h100, 0, 1, 32'hDEADBEEF);
        access(1, 3'b000, 32'h103, 0, 1, 32'h80FF_0000);
        access(1, 3'b100, 32'h103, 0, 2, 32'h80FF_0000);
        access(0, 3'b001, 32'h202, 32'h1234ABCD, 4, 0);
        access(1, 3'b010, 32'h300, 0, 0, 32'h0);

        // Stray acks after the timeout must not start or complete anything.
        bus_ack = 1; bus_rdata = 32'h5555AAAA;
        repeat (2) begin
            @(posedge clk); #1;
            chk("stray_req", bus_req, 0);
            chk("stray_vld", rdata_valid, 0);
            chk("stray_rdata", rdata, exp_rdata);
        end
        bus_ack = 0;
        access(1, 3'b010, 32'h304, 0, 1, 32'hCAFEF00D);

        access(1, 3'b011, 32'h40, 0, 1, 0);
        access(0, 3'b100, 32'h44, 32'h1, 1, 0);
        access(1, 3'b001, 32'h101, 0, 1, 32'h1234_8765);

        // Reset while BUSY drops the access with no DONE pulse.
        mr = 1; mem_type = 3'b010; addr = 32'h400;
        @(posedge clk); #1;
        chk("rstbusy_req", bus_req, 1);
        rst = 1; mr = 0;
        @(posedge clk); #1;
        exp_rdata = 0;
        chk("rstbusy_req0", bus_req, 0);
        chk("rstbusy_pulses", {29'b0, rdata_valid, err, misalign}, 0);
        chk("rstbusy_rdata", rdata, exp_rdata);
        chk("rstbusy_addr", bus_addr, 0);
        rst = 0; bus_ack = 1;
        @(posedge clk); #1;
        bus_ack = 0;
        chk("rstbusy_idle", bus_req, 0);
        chk("rstbusy_novld", rdata_valid, 0);

        for (int i = 0; i < 60; i++) begin
            bit ld;
            logic [2:0] mt;
            ld = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) mt = 3'($urandom_range(0, 7));
            else if (ld) begin
                mt = 3'($urandom_range(0, 4));
                if (mt == 3) mt = 3'b101;
            end else mt = 3'($urandom_range(0, 2));
            access(ld, mt, $urandom, $urandom, $urandom_range(1, 5), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
